// File: rtl/nf10_axis_egress_pkt_fifo_if.sv
// AXI4-Stream bundle (tdata/tstrb/tuser/tvalid/tready/tlast) shared by the ingress and
// egress sides of the egress packet FIFO.
interface nf10_axis_egress_pkt_fifo_if #(
  parameter int DATA_WIDTH  = 256,
  parameter int TUSER_WIDTH = 128
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic [TUSER_WIDTH-1:0]  tuser;
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;

  modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/nf10_axis_egress_pkt_fifo.sv
// Store-and-forward AXIS packet buffer: a packet leaves only once fully stored; overflowing
// packets are dropped whole. Optional packet statistics under `PKT_FIFO_STATS_EN.
module nf10_axis_egress_pkt_fifo #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_DEPTH_LOG2       = 6
) (
  input  logic                         aclk,
  input  logic                         reset,
  nf10_axis_egress_pkt_fifo_if.slave   s_axis,
  nf10_axis_egress_pkt_fifo_if.master  m_axis,
  output logic [7:0]                   drop_cnt,
  output logic [15:0]                  pkt_in_cnt,
  output logic [15:0]                  pkt_out_cnt
);
  localparam int STRB_W = C_AXIS_DATA_WIDTH / 8;
  localparam int DEPTH  = 2 ** C_DEPTH_LOG2;
  localparam int PTR_W  = C_DEPTH_LOG2 + 1;
  localparam int CNT_W  = C_DEPTH_LOG2 + 2;
  localparam int MEM_W  = 1 + C_AXIS_TUSER_WIDTH + STRB_W + C_AXIS_DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  logic [MEM_W-1:0]              mem [DEPTH];
  logic [PTR_W-1:0]              wr_ptr, commit_ptr, rd_ptr, used;
  logic                          full, drop_flag, drop_now, in_pkt;
  logic                          s_beat, wr_en, commit;
  logic [C_AXIS_TUSER_WIDTH-1:0] tuser_hold, cur_tuser;

  state_t                        state, state_next;
  logic [CNT_W-1:0]              pkt_cnt, pkt_cnt_next;
  logic [MEM_W-1:0]              out_word, pf_word;
  logic                          out_valid, pf_valid, out_tlast;
  logic                          pop, pkt_done, avail;
  logic                          load_out, load_pf, pf_to_out, rd_en;

  assign s_axis.tready = ~reset;
  assign s_beat    = s_axis.tvalid & s_axis.tready;
  assign used      = wr_ptr - rd_ptr;
  assign full      = (used == PTR_W'(DEPTH));
  assign drop_now  = drop_flag | full;
  assign wr_en     = s_beat & ~full;
  assign commit    = s_beat & s_axis.tlast & ~drop_now;
  // Later beats carry the first beat's tuser so egress can hold it for the whole packet.
  assign cur_tuser = in_pkt ? tuser_hold : s_axis.tuser;

  always_ff @(posedge aclk) begin
    if (wr_en)
      mem[wr_ptr[C_DEPTH_LOG2-1:0]] <= {s_axis.tlast, cur_tuser, s_axis.tstrb, s_axis.tdata};
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      drop_flag  <= 1'b0;
      in_pkt     <= 1'b0;
      tuser_hold <= '0;
      drop_cnt   <= '0;
    end else if (s_beat) begin
      if (!in_pkt)
        tuser_hold <= s_axis.tuser;
      in_pkt <= ~s_axis.tlast;
      if (s_axis.tlast) begin
        drop_flag <= 1'b0;
        // A tainted packet is erased by rewinding to the last committed boundary.
        if (drop_now) begin
          wr_ptr <= commit_ptr;
          if (drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
        end else begin
          wr_ptr     <= wr_ptr + PTR_W'(1);
          commit_ptr <= wr_ptr + PTR_W'(1);
        end
      end else if (full) begin
        drop_flag <= 1'b1;
      end else begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
    end
  end

  assign out_tlast = out_word[MEM_W-1];
  assign pop       = out_valid & m_axis.tready;
  assign pkt_done  = pop & out_tlast;
  assign avail     = (rd_ptr != commit_ptr);
  assign rd_en     = load_out | load_pf;

  always_comb begin
    pkt_cnt_next = pkt_cnt;
    if (commit && !pkt_done)
      pkt_cnt_next = pkt_cnt + CNT_W'(1);
    else if (!commit && pkt_done)
      pkt_cnt_next = pkt_cnt - CNT_W'(1);
  end

  // Output register plus one prefetch slot; reads only ever target committed beats.
  always_comb begin
    state_next = state;
    load_out   = 1'b0;
    load_pf    = 1'b0;
    pf_to_out  = 1'b0;
    case (state)
      IDLE: if (pkt_cnt != '0) state_next = LOAD;
      LOAD: begin
        load_out   = 1'b1;
        state_next = SEND;
      end
      SEND: begin
        if (!out_valid || pop) begin
          if (pf_valid) begin
            pf_to_out = 1'b1;
            load_pf   = avail;
          end else begin
            load_out  = avail;
          end
        end else if (!pf_valid) begin
          load_pf = avail;
        end
        if (pkt_done && pkt_cnt_next == '0)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      pkt_cnt   <= '0;
      out_word  <= '0;
      out_valid <= 1'b0;
      pf_word   <= '0;
      pf_valid  <= 1'b0;
    end else begin
      state   <= state_next;
      pkt_cnt <= pkt_cnt_next;
      if (rd_en)
        rd_ptr <= rd_ptr + PTR_W'(1);
      if (load_out)
        out_word <= mem[rd_ptr[C_DEPTH_LOG2-1:0]];
      else if (pf_to_out)
        out_word <= pf_word;
      if (load_pf)
        pf_word <= mem[rd_ptr[C_DEPTH_LOG2-1:0]];
      if (load_out || pf_to_out)
        out_valid <= 1'b1;
      else if (pop)
        out_valid <= 1'b0;
      if (load_pf)
        pf_valid <= 1'b1;
      else if (pf_to_out)
        pf_valid <= 1'b0;
    end
  end

  assign m_axis.tvalid = out_valid;
  assign m_axis.tdata  = out_word[C_AXIS_DATA_WIDTH-1:0];
  assign m_axis.tstrb  = out_word[C_AXIS_DATA_WIDTH +: STRB_W];
  assign m_axis.tuser  = out_word[C_AXIS_DATA_WIDTH + STRB_W +: C_AXIS_TUSER_WIDTH];
  assign m_axis.tlast  = out_tlast;

`ifdef PKT_FIFO_STATS_EN
  always_ff @(posedge aclk) begin
    if (reset) begin
      pkt_in_cnt  <= '0;
      pkt_out_cnt <= '0;
    end else begin
      if (commit)
        pkt_in_cnt <= pkt_in_cnt + 16'd1;
      if (pkt_done)
        pkt_out_cnt <= pkt_out_cnt + 16'd1;
    end
  end
`else
  assign pkt_in_cnt  = '0;
  assign pkt_out_cnt = '0;
`endif

endmodule
